// File: rtl/barrett_modmul_pipe.sv
// barrett_modmul_pipe
//   Pipelined Barrett modular engine. Each accepted operation forms
//   x = a*b (mode 0) or x = {a,b} (mode 1) and returns x mod m, where m, mu
//   and k come from a runtime-loaded configuration. x must be below m^2.
//   The engine sustains one operation per cycle, and results return in order.
//
// Ports
//   clk_i, rst_i             : clock, synchronous active-high reset
//   cfg_we_i, cfg_m_i,
//   cfg_mu_i, cfg_k_i        : configuration write (honoured only when idle)
//   in_valid_i / in_ready_o  : input handshake
//   mode_i, a_i, b_i, tag_i  : operation, operands and opaque tag
//   out_valid_o / out_ready_i: output handshake
//   result_o, tag_o, err_o   : x mod m, tag, range-violation flag
//   busy_o                   : some pipeline stage holds an operation
//   cfg_valid_o              : a configuration has been loaded
//   done_cnt_o               : count of output handshakes (wraps)
//
// Pipeline: S1 operands -> S2 {x, q2} -> S3 {x, p} -> S4 r = x - p -> output
// register after the conditional subtractions. An input accepted at edge N
// is presented after edge N+4.
module barrett_modmul_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [WIDTH-1:0]       cfg_m_i,
    input  logic [WIDTH:0]         cfg_mu_i,
    input  logic [$clog2(WIDTH):0] cfg_k_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   mode_i,
    input  logic [WIDTH-1:0]       a_i,
    input  logic [WIDTH-1:0]       b_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH-1:0]       result_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   cfg_valid_o,
    output logic [CNT_W-1:0]       done_cnt_o
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int XW = 2 * WIDTH;      // x
    localparam int PW = 2 * WIDTH + 1;  // p and r
    localparam int QW = 3 * WIDTH + 1;  // q2 = q1 * mu

    // configuration
    logic             cfg_valid_q, cfg_valid_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   mu_q, mu_d;
    logic [KW-1:0]    k_q, k_d;

    // S1
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // S2
    logic             s2_valid_q, s2_valid_d;
    logic [XW-1:0]    s2_x_q, s2_x_d;
    logic [QW-1:0]    s2_q2_q, s2_q2_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    // S3
    logic             s3_valid_q, s3_valid_d;
    logic [XW-1:0]    s3_x_q, s3_x_d;
    logic [PW-1:0]    s3_p_q, s3_p_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;

    // S4
    logic             s4_valid_q, s4_valid_d;
    logic [PW-1:0]    s4_r_q, s4_r_d;
    logic [TAG_W-1:0] s4_tag_q, s4_tag_d;

    // output register
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // combinational helpers
    logic             stall;
    logic             busy;
    logic             in_ready;
    logic             accept;
    logic             cfg_ok;
    logic [XW-1:0]    x_comb;
    logic [XW-1:0]    q1_comb;
    logic [PW-1:0]    m_ext;
    logic [PW-1:0]    r_fix;

    always_comb begin
        cfg_valid_d = cfg_valid_q;
        m_d         = m_q;
        mu_d        = mu_q;
        k_d         = k_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_x_d      = s2_x_q;
        s2_q2_d     = s2_q2_q;
        s2_tag_d    = s2_tag_q;
        s3_valid_d  = s3_valid_q;
        s3_x_d      = s3_x_q;
        s3_p_d      = s3_p_q;
        s3_tag_d    = s3_tag_q;
        s4_valid_d  = s4_valid_q;
        s4_r_d      = s4_r_q;
        s4_tag_d    = s4_tag_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        tag_d       = tag_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        stall    = out_valid_q & ~out_ready_i;
        busy     = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q | out_valid_q;
        in_ready = cfg_valid_q & ~stall & ~cfg_we_i;
        accept   = in_valid_i & in_ready;
        cfg_ok   = cfg_we_i & ~busy;

        // S1 -> S2: form x, then q1 = x >> (k-1), q2 = q1 * mu
        x_comb  = s1_mode_q ? {s1_a_q, s1_b_q} : XW'(s1_a_q) * XW'(s1_b_q);
        q1_comb = x_comb >> (k_q - KW'(1));

        // S4 -> out: at most two corrections; anything still >= m breaks x < m^2
        m_ext = PW'(m_q);
        r_fix = s4_r_q;
        if (r_fix >= m_ext) r_fix = r_fix - m_ext;
        if (r_fix >= m_ext) r_fix = r_fix - m_ext;

        if (cfg_ok) begin
            cfg_valid_d = 1'b1;
            m_d         = cfg_m_i;
            mu_d        = cfg_mu_i;
            k_d         = cfg_k_i;
        end

        // a single global stall freezes every stage, so order is trivially kept
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d    = a_i;
                s1_b_d    = b_i;
                s1_mode_d = mode_i;
                s1_tag_d  = tag_i;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_x_d   = x_comb;
                s2_q2_d  = QW'(q1_comb) * QW'(mu_q);
                s2_tag_d = s1_tag_q;
            end

            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_x_d   = s2_x_q;
                // only the low PW bits of q3 can reach the truncated product
                s3_p_d   = PW'(s2_q2_q >> (k_q + KW'(1))) * m_ext;
                s3_tag_d = s2_tag_q;
            end

            s4_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                s4_r_d   = PW'(s3_x_q) - s3_p_q;
                s4_tag_d = s3_tag_q;
            end

            out_valid_d = s4_valid_q;
            if (s4_valid_q) begin
                result_d = r_fix[WIDTH-1:0];
                err_d    = (r_fix >= m_ext);
                tag_d    = s4_tag_q;
            end
        end

        if (out_valid_q & out_ready_i) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_valid_q <= 1'b0;
            m_q         <= '0;
            mu_q        <= '0;
            k_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_q2_q     <= '0;
            s2_tag_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_x_q      <= '0;
            s3_p_q      <= '0;
            s3_tag_q    <= '0;
            s4_valid_q  <= 1'b0;
            s4_r_q      <= '0;
            s4_tag_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cfg_valid_q <= cfg_valid_d;
            m_q         <= m_d;
            mu_q        <= mu_d;
            k_q         <= k_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_q2_q     <= s2_q2_d;
            s2_tag_q    <= s2_tag_d;
            s3_valid_q  <= s3_valid_d;
            s3_x_q      <= s3_x_d;
            s3_p_q      <= s3_p_d;
            s3_tag_q    <= s3_tag_d;
            s4_valid_q  <= s4_valid_d;
            s4_r_q      <= s4_r_d;
            s4_tag_q    <= s4_tag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign busy_o      = busy;
    assign cfg_valid_o = cfg_valid_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign tag_o       = tag_q;
    assign err_o       = err_q;
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_barrett_modmul_pipe.sv
// tb_barrett_modmul_pipe
//   Directed bench for barrett_modmul_pipe (WIDTH=64, TAG_W=4, CNT_W=32).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_barrett_modmul_pipe;

    localparam logic [63:0] M32 = 64'h0000_0000_9215_3525;

    logic        clk;
    logic        rst_i;
    logic        cfg_we_i;
    logic [63:0] cfg_m_i;
    logic [64:0] cfg_mu_i;
    logic [6:0]  cfg_k_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        mode_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic [3:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic [3:0]  tag_o;
    logic        err_o;
    logic        busy_o;
    logic        cfg_valid_o;
    logic [31:0] done_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    barrett_modmul_pipe #(.WIDTH(64), .TAG_W(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_m_i(cfg_m_i), .cfg_mu_i(cfg_mu_i), .cfg_k_i(cfg_k_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .tag_o(tag_o), .err_o(err_o),
        .busy_o(busy_o), .cfg_valid_o(cfg_valid_o), .done_cnt_o(done_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic load_cfg(input logic [63:0] m, input logic [64:0] mu, input logic [6:0] k);
        cfg_we_i = 1'b1; cfg_m_i = m; cfg_mu_i = mu; cfg_k_i = k;
        @(negedge clk);
        cfg_we_i = 1'b0;
    endtask

    task automatic send_one(input logic md, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] t, output int acc, output bit ok);
        mode_i = md; a_i = a; b_i = b; tag_i = t; in_valid_i = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        acc = cyc;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        in_valid_i = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_no_cfg: got %0h want 0", in_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy_o); end
        n_cmp++; if (cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %0h want 0", cfg_valid_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err_o); end
        n_cmp++; if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %0h want 0", result_o); end
        n_cmp++; if (tag_o !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0h want 0", tag_o); end
        n_cmp++; if (done_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt_o); end
        in_valid_i = 1'b0;
        @(negedge clk);
        // no operation may have slipped in without a configuration
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: busy got %0h want 0", busy_o); end
    endtask

    task automatic test_small_mode0();
        int acc; bit ok; bit okv;
        load_cfg(64'd13, 65'd19, 7'd4);
        n_cmp++; if (cfg_valid_o !== 1'b1) begin n_fail++; $display("FAIL cfg_valid_after_load: got %0h want 1", cfg_valid_o); end
        send_one(1'b0, 64'd12, 64'd12, 4'd3, acc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL small_accept: got %0h want 1", ok); end
        wait_valid(okv);
        n_cmp++; if (okv !== 1'b1) begin n_fail++; $display("FAIL small_out_timeout: got %0h want 1", okv); end
        n_cmp++; if (cyc - acc !== 4) begin n_fail++; $display("FAIL small_latency: got %0d want 4", cyc - acc); end
        n_cmp++; if (result_o !== 64'd1) begin n_fail++; $display("FAIL small_result: got %0d want 1", result_o); end
        n_cmp++; if (tag_o !== 4'd3) begin n_fail++; $display("FAIL small_tag: got %0d want 3", tag_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL small_err: got %0h want 0", err_o); end
        @(negedge clk);
        n_cmp++; if (done_cnt_o !== 32'd1) begin n_fail++; $display("FAIL small_done_cnt: got %0d want 1", done_cnt_o); end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL small_no_duplicate: got %0h want 0", out_valid_o); end
    endtask

    task automatic test_reduce_mode();
        int acc; bit ok; bit okv;
        send_one(1'b1, 64'd0, 64'd168, 4'd5, acc, ok);
        wait_valid(okv);
        n_cmp++; if (okv !== 1'b1) begin n_fail++; $display("FAIL reduce_out_timeout: got %0h want 1", okv); end
        n_cmp++; if (result_o !== 64'd12) begin n_fail++; $display("FAIL reduce_result: got %0d want 12", result_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reduce_err: got %0h want 0", err_o); end
        n_cmp++; if (tag_o !== 4'd5) begin n_fail++; $display("FAIL reduce_tag: got %0d want 5", tag_o); end
        @(negedge clk);
        send_one(1'b1, 64'd1, 64'd0, 4'd6, acc, ok);
        wait_valid(okv);
        n_cmp++; if (okv !== 1'b1) begin n_fail++; $display("FAIL range_out_timeout: got %0h want 1", okv); end
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL range_err: got %0h want 1", err_o); end
        n_cmp++; if (tag_o !== 4'd6) begin n_fail++; $display("FAIL range_tag: got %0d want 6", tag_o); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [63:0] sa[100];
        logic [63:0] sb[100];
        logic [63:0] eq[$];
        logic [3:0]  tq[$];
        logic [64:0] pow64;
        logic [64:0] mu;
        int sent; int got;
        sent = 0; got = 0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        pow64 = '0;
        pow64[64] = 1'b1;
        mu = pow64 / {1'b0, M32};
        for (int i = 0; i < 100; i++) begin
            sa[i] = {32'd0, $urandom()} % M32;
            sb[i] = {32'd0, $urandom()} % M32;
        end
        load_cfg(M32, mu, 7'd32);
        out_ready_i = 1'b1;
        for (int t = 0; t < 400 && got < 100; t++) begin
            in_valid_i = (sent < 100);
            if (sent < 100) begin mode_i = 1'b0; a_i = sa[sent]; b_i = sb[sent]; tag_i = sent[3:0]; end
            #1;
            if (out_valid_o && out_ready_i) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL stream_extra_output: got result %0h want none", result_o);
                end else begin
                    n_cmp++; if (result_o !== eq[0]) begin n_fail++; $display("FAIL stream_result[%0d]: got %0h want %0h", got, result_o, eq[0]); end
                    n_cmp++; if (tag_o !== tq[0]) begin n_fail++; $display("FAIL stream_tag[%0d]: got %0h want %0h", got, tag_o, tq[0]); end
                    void'(eq.pop_front()); void'(tq.pop_front());
                end
                got++;
            end
            if (in_valid_i && in_ready_o) begin
                eq.push_back((sa[sent] * sb[sent]) % M32);
                tq.push_back(sent[3:0]);
                sent++;
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        n_cmp++; if (got !== 100) begin n_fail++; $display("FAIL stream_count: got %0d want 100", got); end
        n_cmp++; if (done_cnt_o !== 32'd100) begin n_fail++; $display("FAIL stream_done_cnt: got %0d want 100", done_cnt_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL stream_busy_after: got %0h want 0", busy_o); end
    endtask

    task automatic test_cfg_gating();
        int acc; bit ok; bit okv;
        // m-1 times 2 under the 32-bit modulus gives m-2
        send_one(1'b0, M32 - 64'd1, 64'd2, 4'd7, acc, ok);
        cfg_we_i = 1'b1; cfg_m_i = 64'd13; cfg_mu_i = 65'd19; cfg_k_i = 7'd4;
        #1;
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL gate_busy: got %0h want 1", busy_o); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL gate_in_ready_cfg_we: got %0h want 0", in_ready_o); end
        @(negedge clk);
        cfg_we_i = 1'b0;
        wait_valid(okv);
        n_cmp++; if (okv !== 1'b1) begin n_fail++; $display("FAIL gate_out_timeout: got %0h want 1", okv); end
        n_cmp++; if (result_o !== 64'h9215_3523) begin n_fail++; $display("FAIL gate_old_m_result: got %0h want 92153523", result_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL gate_err: got %0h want 0", err_o); end
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL gate_drained: got %0h want 0", busy_o); end
        load_cfg(64'd13, 65'd19, 7'd4);
        send_one(1'b0, 64'd12, 64'd12, 4'd8, acc, ok);
        wait_valid(okv);
        n_cmp++; if (result_o !== 64'd1) begin n_fail++; $display("FAIL gate_new_m_result: got %0d want 1", result_o); end
        n_cmp++; if (tag_o !== 4'd8) begin n_fail++; $display("FAIL gate_new_m_tag: got %0d want 8", tag_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [63:0] va[6];
        logic [63:0] vb[6];
        logic [63:0] vr[6];
        logic [63:0] eq[$];
        logic [3:0]  tq[$];
        int sent; int got; int base; int stalls;
        va = '{64'd2, 64'd5, 64'd7, 64'd12, 64'd9, 64'd10};
        vb = '{64'd3, 64'd5, 64'd8, 64'd11, 64'd9, 64'd4};
        vr = '{64'd6, 64'd12, 64'd4, 64'd2, 64'd3, 64'd1};
        sent = 0; got = 0; stalls = 0;
        base = int'(done_cnt_o);
        for (int t = 0; t < 60 && got < 6; t++) begin
            out_ready_i = !(t >= 5 && t <= 7);
            in_valid_i = (sent < 6) && (t != 3);
            if (sent < 6) begin mode_i = 1'b0; a_i = va[sent]; b_i = vb[sent]; tag_i = 4'(sent + 1); end
            #1;
            if (out_valid_o && !out_ready_i) begin
                stalls++;
                n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall: got %0h want 0", in_ready_o); end
                if (eq.size() != 0) begin
                    n_cmp++; if (result_o !== eq[0]) begin n_fail++; $display("FAIL bp_held_result: got %0d want %0d", result_o, eq[0]); end
                    n_cmp++; if (tag_o !== tq[0]) begin n_fail++; $display("FAIL bp_held_tag: got %0d want %0d", tag_o, tq[0]); end
                end
            end
            if (out_valid_o && out_ready_i) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL bp_extra_output: got tag %0d want none", tag_o);
                end else begin
                    n_cmp++; if (result_o !== eq[0]) begin n_fail++; $display("FAIL bp_result[%0d]: got %0d want %0d", got, result_o, eq[0]); end
                    n_cmp++; if (tag_o !== tq[0]) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d want %0d", got, tag_o, tq[0]); end
                    void'(eq.pop_front()); void'(tq.pop_front());
                end
                got++;
            end
            if (in_valid_i && in_ready_o) begin
                eq.push_back(vr[sent]);
                tq.push_back(4'(sent + 1));
                sent++;
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got); end
        n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stalls); end
        n_cmp++; if (done_cnt_o !== 32'(base + 6)) begin n_fail++; $display("FAIL bp_done_cnt: got %0d want %0d", done_cnt_o, base + 6); end
    endtask

    task automatic test_reset_midflight();
        int acc; bit ok; bit okv; int stale;
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            mode_i = 1'b0; a_i = 64'd3; b_i = 64'(i + 1); tag_i = 4'(i + 10); in_valid_i = 1'b1;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_busy: got %0h want 1", busy_o); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %0h want 0", out_valid_o); end
        n_cmp++; if (cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cfg_valid: got %0h want 0", cfg_valid_o); end
        n_cmp++; if (done_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_mid_done_cnt: got %0d want 0", done_cnt_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0h want 0", busy_o); end
        for (int i = 0; i < 6; i++) begin
            if (out_valid_o) stale++;
            @(negedge clk);
        end
        load_cfg(64'd13, 65'd19, 7'd4);
        for (int i = 0; i < 6; i++) begin
            if (out_valid_o) stale++;
            @(negedge clk);
        end
        n_cmp++; if (stale !== 0) begin n_fail++; $display("FAIL rst_mid_stale_outputs: got %0d want 0", stale); end
        send_one(1'b0, 64'd5, 64'd5, 4'd9, acc, ok);
        wait_valid(okv);
        n_cmp++; if (result_o !== 64'd12) begin n_fail++; $display("FAIL rst_mid_after_result: got %0d want 12", result_o); end
        n_cmp++; if (tag_o !== 4'd9) begin n_fail++; $display("FAIL rst_mid_after_tag: got %0d want 9", tag_o); end
        @(negedge clk);
        n_cmp++; if (done_cnt_o !== 32'd1) begin n_fail++; $display("FAIL rst_mid_after_cnt: got %0d want 1", done_cnt_o); end
    endtask

    initial begin
        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_m_i = '0; cfg_mu_i = '0; cfg_k_i = '0;
        in_valid_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0; tag_i = '0;
        out_ready_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_small_mode0();
        test_reduce_mode();
        test_stream();
        test_cfg_gating();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
